// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, polarity fix and debounce for
// slow asynchronous board inputs (buttons, smoke, PIR, limit switches).
//
// Optional feature macro: INPUT_COND_EDGE_EN
//   defined   -> rise_o / fall_o pulses and sticky changed_o flags are built
//   undefined -> rise_o, fall_o, changed_o tied to 0, clr_i ignored
//
// Ports
//   clk        system clock (single domain)
//   reset_n    asynchronous active-low reset
//   raw_i      [NUM_CH] asynchronous pins
//   clr_i      synchronous clear of changed_o
//   level_o    [NUM_CH] debounced, polarity-corrected level
//   rise_o     [NUM_CH] one-cycle pulse, clock after level_o goes 0->1
//   fall_o     [NUM_CH] one-cycle pulse, clock after level_o goes 1->0
//   changed_o  [NUM_CH] sticky "level changed" flag

// Per-channel lane: 2-flop sync, polarity, 4-state debounce FSM, edge/sticky.
module input_conditioner_ch #(
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter logic INV             = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic changed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter runs up to DEBOUNCE_CYCLES; the transition fires on the sample
  // after that, giving DEBOUNCE_CYCLES+2 clocks from pin to level.
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] PEND_HI   = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] PEND_LO   = 2'd3;

  logic [1:0]    sync;
  logic          s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  // Reset to the idle pin level so an idle active-low input looks idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= {2{INV}};
    else          sync <= {sync[0], raw};
  end

  assign s = sync[1] ^ INV;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        STABLE_LO: if (s) begin
          state <= PEND_HI;
          cnt   <= CW'(1);
        end
        PEND_HI: begin
          if (!s) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= STABLE_HI;
            cnt   <= '0;
            level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HI: if (!s) begin
          state <= PEND_LO;
          cnt   <= CW'(1);
        end
        default: begin // PEND_LO
          if (s) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef INPUT_COND_EDGE_EN
  logic level_d;
  logic chg_now;

  assign chg_now = level ^ level_d;

  // The pulse cycle itself also counts as a set, so a clear landing while
  // rise/fall is high cannot wipe out the event it is reporting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      changed <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
      fall    <= ~level & level_d;
      changed <= (changed & ~clr) | chg_now | rise | fall;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign rise       = 1'b0;
  assign fall       = 1'b0;
  assign changed    = 1'b0;
`endif
endmodule

module input_conditioner #(
  parameter int                NUM_CH          = 8,
  parameter int                DEBOUNCE_CYCLES = 1000000,
  parameter logic [NUM_CH-1:0] INVERT_MASK     = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] raw_i,
  input  logic              clr_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] changed_o
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_conditioner_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INV             (INVERT_MASK[i])
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw_i[i]),
      .clr     (clr_i),
      .level   (level_o[i]),
      .rise    (rise_o[i]),
      .fall    (fall_o[i]),
      .changed (changed_o[i])
    );
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (NUM_CH=4, DEBOUNCE_CYCLES=4,
// INVERT_MASK=4'b1000). Reference model: per-channel run length of samples
// disagreeing with the current level; a run of DEBOUNCE_CYCLES+1 flips it.
// Edge/sticky expectations come from toggle and clear timestamps.
module tb_input_conditioner;
  localparam int         NCH  = 4;
  localparam int         DC   = 4;
  localparam logic [3:0] MASK = 4'b1000;
`ifdef INPUT_COND_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr_i = 1'b0;
  logic [3:0] raw_i = MASK;
  logic [3:0] level_o, rise_o, fall_o, changed_o;

  input_conditioner #(.NUM_CH(NCH), .DEBOUNCE_CYCLES(DC), .INVERT_MASK(MASK)) dut (
    .clk(clk), .reset_n(reset_n), .raw_i(raw_i), .clr_i(clr_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .changed_o(changed_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int now = 0;

  // model state
  logic [3:0] h1, h2, m_level;
  int m_run [NCH];
  int m_tog [NCH];
  int m_prev [NCH];
  int m_clr;
  logic [3:0] e_rise, e_fall, e_chg;

  task automatic model_reset();
    h1 = MASK; h2 = MASK; m_level = '0; m_clr = -100;
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_tog[i] = -100; m_prev[i] = -100;
    end
    e_rise = '0; e_fall = '0; e_chg = '0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic c);
    logic [3:0] s;
    int eff;
    now++;
    if (!reset_n) begin
      model_reset();
    end else begin
      s = h2 ^ MASK;  // pin level seen two edges ago, polarity-corrected
      h2 = h1; h1 = r;
      for (int i = 0; i < NCH; i++) begin
        if (s[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DC + 1) begin
            m_level[i] = ~m_level[i];
            m_run[i] = 0;
            m_prev[i] = m_tog[i];
            m_tog[i] = now;
          end
        end else m_run[i] = 0;
      end
      if (c) m_clr = now;
      for (int i = 0; i < NCH; i++) begin
        eff = (m_tog[i] == now) ? m_prev[i] : m_tog[i];
        e_rise[i] = EDGE && (m_tog[i] == now - 1) && m_level[i];
        e_fall[i] = EDGE && (m_tog[i] == now - 1) && !m_level[i];
        // a clear only removes the flag from the second edge after the set
        e_chg[i]  = EDGE && (eff >= 0) && (m_clr < eff + 3);
      end
    end
  endtask

  task automatic tick(input logic [3:0] r, input logic c);
    raw_i = r; clr_i = c;
    @(posedge clk);
    model_step(r, c);
    #1;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0; raw_i = MASK; clr_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; raw_i = MASK; clr_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({level_o, rise_o, fall_o, changed_o} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got lvl=%b r=%b f=%b c=%b want all 0", level_o, rise_o, fall_o, changed_o);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(MASK, 1'b0);
      checks++;
      if ({level_o, rise_o, fall_o} !== 12'h0) begin
        failures++;
        $display("FAIL reset_idle k=%0d: got lvl=%b r=%b f=%b want 0", k, level_o, rise_o, fall_o);
      end
    end
  endtask

  task automatic test_clean_rise();
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      tick(4'b1001, 1'b0);
      checks++;
      if (level_o[0] !== (k >= 6) || rise_o[0] !== (EDGE && k == 7) ||
          changed_o[0] !== (EDGE && k >= 7) || fall_o[0] !== 1'b0) begin
        failures++;
        $display("FAIL clean_rise edge=%0d: got lvl=%b r=%b f=%b c=%b want lvl=%0d r=%0d c=%0d",
                 k, level_o[0], rise_o[0], fall_o[0], changed_o[0], k >= 6, EDGE && k == 7, EDGE && k >= 7);
      end
    end
  endtask

  task automatic test_glitch();
    reset_dut();
    for (int k = 0; k < 15; k++) begin
      tick((k < 3) ? 4'b1010 : 4'b1000, 1'b0);
      checks++;
      if (level_o[1] !== 1'b0 || rise_o[1] !== 1'b0 || changed_o[1] !== 1'b0 || level_o !== m_level) begin
        failures++;
        $display("FAIL glitch k=%0d: got lvl=%b r=%b c=%b want lvl[1]=0 r=0 c=0 lvl=%b",
                 k, level_o, rise_o[1], changed_o[1], m_level);
      end
    end
  endtask

  task automatic test_active_low();
    int nfall = 0;
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      tick(4'b0000, 1'b0);
      checks++;
      if (level_o[3] !== (k >= 6)) begin
        failures++;
        $display("FAIL active_low_rise k=%0d: got %b want %0d", k, level_o[3], k >= 6);
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(4'b1000, 1'b0);
      if (fall_o[3] === 1'b1) nfall++;
      checks++;
      if (level_o[3] !== (k < 6)) begin
        failures++;
        $display("FAIL active_low_fall k=%0d: got %b want %0d", k, level_o[3], k < 6);
      end
    end
    checks++;
    if (nfall != (EDGE ? 1 : 0)) begin
      failures++;
      $display("FAIL active_low_fall_pulses: got %0d want %0d", nfall, EDGE ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int k = 0; k < 4; k++) tick(4'b1100, 1'b0);  // counter now at 2
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({level_o, rise_o, fall_o, changed_o} !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got lvl=%b r=%b f=%b c=%b want 0", level_o, rise_o, fall_o, changed_o);
    end
    tick(4'b1100, 1'b0);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(4'b1100, 1'b0);
      checks++;
      if (level_o[2] !== (k >= 6)) begin
        failures++;
        $display("FAIL reset_mid_rise k=%0d: got %b want %0d", k, level_o[2], k >= 6);
      end
    end
  endtask

  task automatic test_clr();
    bit seen = 0;
    reset_dut();
    for (int k = 0; k < 10; k++) tick(4'b1001, 1'b0);
`ifdef INPUT_COND_EDGE_EN
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(4'b1000, 1'b0);
      if (fall_o[0] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL clr_fall_timeout: got no fall_o[0] want one pulse");
    end
    tick(4'b1000, 1'b1);  // clear during the fall pulse: set wins
    checks++;
    if (changed_o[0] !== 1'b1 || changed_o !== e_chg) begin
      failures++;
      $display("FAIL clr_same_cycle: got c=%b want c[0]=1 model=%b", changed_o, e_chg);
    end
    tick(4'b1000, 1'b1);
    checks++;
    if (changed_o !== 4'b0000) begin
      failures++;
      $display("FAIL clr_next_cycle: got %b want 0000", changed_o);
    end
`else
    for (int k = 0; k < 20; k++) begin
      tick(4'b1000, k[0]);
      checks++;
      if ({rise_o, fall_o, changed_o} !== 12'h0) begin
        failures++;
        $display("FAIL edge_disabled k=%0d: got r=%b f=%b c=%b want 0", k, rise_o, fall_o, changed_o);
      end
    end
`endif
    tick(4'b1000, 1'b0);
    checks++;
    if (seen == EDGE && level_o !== m_level) begin
      failures++;
      $display("FAIL clr_level: got %b want %b", level_o, m_level);
    end
  endtask

  task automatic test_random();
    logic [3:0] r = MASK;
    reset_dut();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      tick(r, $urandom_range(0, 15) == 0);
      checks++;
      if (level_o !== m_level || rise_o !== e_rise || fall_o !== e_fall || changed_o !== e_chg) begin
        failures++;
        $display("FAIL random k=%0d: got lvl=%b r=%b f=%b c=%b want lvl=%b r=%b f=%b c=%b",
                 k, level_o, rise_o, fall_o, changed_o, m_level, e_rise, e_fall, e_chg);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_clean_rise();
    test_glitch();
    test_active_low();
    test_reset_mid();
    test_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
